afifo_wr_ctrl: RTL and testbench

//   Write-domain controller of the asynchronous CDC FIFO. Owns the binary/Gray write pointer
//   and the RAM write address/enable. Brings the read pointer into clk through an internal
//   two-flop synchronizer. Generates full, almost_full, a fill estimate and a sticky overflow flag.

---
 rtl/afifo_pkg.sv | 25 ++
 rtl/afifo_wr_ctrl_if.sv | 24 ++
 rtl/afifo_wr_ctrl_sync_2ff.sv | 27 ++
 rtl/afifo_wr_ctrl.sv | 82 ++++++++
 tb/tb_afifo_wr_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/afifo_pkg.sv
// Helpers shared by both controllers of the asynchronous FIFO.
// Functions work on a wide container; callers cut the result to their pointer width.
package afifo_pkg;

    localparam int PTR_MAX = 32;
    typedef logic [PTR_MAX-1:0] ptr_wide_t;

    function automatic int unsigned fifo_depth(input int unsigned addrsize);
        return 32'd1 << addrsize;
    endfunction

    function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
        ptr_wide_t b;
        b = g;
        for (int i = 1; i < PTR_MAX; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_wr_ctrl_if.sv
// Write-side bundle: producer requests, read pointer from the other domain,
// and the controller's RAM/flag outputs.
interface afifo_wr_ctrl_if #(parameter int ADDRSIZE = 8);
    logic                wr_en;
    logic                clr_ovf;
    logic [ADDRSIZE:0]   rptr_gray;
    logic [ADDRSIZE-1:0] waddr;
    logic                wram_we;
    logic [ADDRSIZE:0]   wptr_gray;
    logic                full;
    logic                almost_full;
    logic [ADDRSIZE:0]   wr_count;
    logic                overflow;

    modport master (
        output wr_en, clr_ovf, rptr_gray,
        input  waddr, wram_we, wptr_gray, full, almost_full, wr_count, overflow
    );

    modport slave (
        input  wr_en, clr_ovf, rptr_gray,
        output waddr, wram_we, wptr_gray, full, almost_full, wr_count, overflow
    );
endinterface

// File: rtl/afifo_wr_ctrl_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into clk.
// Only one bit changes per step, so a metastable sample resolves to old or new.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: write pointer, RAM write strobe,
// and full / almost_full / fill / sticky overflow flags against the synced read pointer.
module afifo_wr_ctrl
    import afifo_pkg::*;
#(
    parameter int ADDRSIZE  = 8,
    parameter int AF_MARGIN = 4
) (
    input logic            clk,
    input logic            rst_n,
    afifo_wr_ctrl_if.slave bus
);

    localparam int PW    = ADDRSIZE + 1;
    localparam int DEPTH = int'(fifo_depth(ADDRSIZE));
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] wbin_reg;
    logic [PW-1:0] wgray_reg;
    logic [PW-1:0] wr_count_reg;
    logic          full_reg;
    logic          almost_full_reg;
    logic          overflow_reg;

    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rq2;
    logic [PW-1:0] rbin;
    logic [PW-1:0] fill_next;
    logic [PW-1:0] full_match;
    logic          winc;

    sync_2ff #(.WIDTH(PW)) u_rptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rptr_gray),
        .q     (rq2)
    );

    // Full when the next write pointer is one lap ahead of the read pointer:
    // in Gray that is the read pointer with its two top bits inverted.
    always_comb begin
        winc       = bus.wr_en & ~full_reg;
        wbin_next  = wbin_reg + PW'(winc);
        wgray_next = PW'(bin2gray(ptr_wide_t'(wbin_next)));
        rbin       = PW'(gray2bin(ptr_wide_t'(rq2)));
        fill_next  = wbin_next - rbin;
        full_match = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_reg        <= '0;
            wgray_reg       <= '0;
            wr_count_reg    <= '0;
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            wbin_reg        <= wbin_next;
            wgray_reg       <= wgray_next;
            wr_count_reg    <= fill_next;
            full_reg        <= (wgray_next == full_match);
            almost_full_reg <= (fill_next >= AF_LEVEL);
            // A rejected write outranks a simultaneous clear.
            if (bus.wr_en && full_reg) begin
                overflow_reg <= 1'b1;
            end else if (bus.clr_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign bus.waddr       = wbin_reg[ADDRSIZE-1:0];
    assign bus.wram_we     = winc;
    assign bus.wptr_gray   = wgray_reg;
    assign bus.full        = full_reg;
    assign bus.almost_full = almost_full_reg;
    assign bus.wr_count    = wr_count_reg;
    assign bus.overflow    = overflow_reg;

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Bench for afifo_wr_ctrl at ADDRSIZE=3, AF_MARGIN=2: directed vector table,
// hand sequences for reset/release/wrap, then random traffic against a count-based model.
module tb_afifo_wr_ctrl;

    logic clk;
    logic rst_n;

    afifo_wr_ctrl_if #(.ADDRSIZE(3)) bus ();

    afifo_wr_ctrl #(.ADDRSIZE(3), .AF_MARGIN(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: total accepted writes, read positions seen per edge, registered flags.
    int m_wtot;
    int m_cnt;
    bit m_full;
    bit m_af;
    bit m_ovf;
    int rhist[$];

    int pre_we;
    int pre_waddr;

    typedef struct {
        bit wr;
        bit clr;
        bit we;
        int waddr;
        bit full;
        bit af;
        int cnt;
        int gray;
        bit ovf;
    } vec_t;

    vec_t vecs[14];

    function automatic int g4(input int b);
        int x;
        x = b & 15;
        return x ^ (x >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_wtot = 0;
        m_cnt  = 0;
        m_full = 1'b0;
        m_af   = 1'b0;
        m_ovf  = 1'b0;
        rhist.delete();
        rhist.push_back(0);
        rhist.push_back(0);
    endtask

    // The flags registered at an edge see the read position driven two edges earlier.
    task automatic model_edge(input bit wr, input bit clr, input int rb);
        bit acc;
        bit rej;
        int rs;
        int fill;
        acc = wr && !m_full;
        rej = wr && m_full;
        rhist.push_back(rb);
        rs = rhist[rhist.size()-3];
        if (rhist.size() > 8) void'(rhist.pop_front());
        if (acc) m_wtot++;
        fill   = (m_wtot - rs) & 15;
        m_cnt  = fill;
        m_full = (fill == 8);
        m_af   = (fill >= 6);
        if (rej) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic cycle(input bit wr, input bit clr, input int rb);
        bus.wr_en     = wr;
        bus.clr_ovf   = clr;
        bus.rptr_gray = 4'(g4(rb));
        #1;
        pre_we    = int'(bus.wram_we);
        pre_waddr = int'(bus.waddr);
        check("wram_we", pre_we, int'(wr && !m_full));
        check("waddr", pre_waddr, m_wtot & 7);
        @(posedge clk);
        model_edge(wr, clr, rb);
        #1;
        check("full", int'(bus.full), int'(m_full));
        check("almost_full", int'(bus.almost_full), int'(m_af));
        check("wr_count", int'(bus.wr_count), m_cnt);
        check("wptr_gray", int'(bus.wptr_gray), g4(m_wtot));
        check("overflow", int'(bus.overflow), int'(m_ovf));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb_i;
        int prev_gray;
        int wrap_seen;
        bit wr;
        bit clr;

        vecs[0]  = '{1, 0, 1, 0, 0, 0, 1,  1, 0};
        vecs[1]  = '{1, 0, 1, 1, 0, 0, 2,  3, 0};
        vecs[2]  = '{1, 0, 1, 2, 0, 0, 3,  2, 0};
        vecs[3]  = '{1, 0, 1, 3, 0, 0, 4,  6, 0};
        vecs[4]  = '{1, 0, 1, 4, 0, 0, 5,  7, 0};
        vecs[5]  = '{1, 0, 1, 5, 0, 1, 6,  5, 0};
        vecs[6]  = '{1, 0, 1, 6, 0, 1, 7,  4, 0};
        vecs[7]  = '{1, 0, 1, 7, 1, 1, 8, 12, 0};
        vecs[8]  = '{1, 0, 0, 0, 1, 1, 8, 12, 1};
        vecs[9]  = '{1, 0, 0, 0, 1, 1, 8, 12, 1};
        vecs[10] = '{1, 0, 0, 0, 1, 1, 8, 12, 1};
        vecs[11] = '{0, 1, 0, 0, 1, 1, 8, 12, 0};
        vecs[12] = '{1, 1, 0, 0, 1, 1, 8, 12, 1};
        vecs[13] = '{0, 1, 0, 0, 1, 1, 8, 12, 0};

        rst_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.clr_ovf   = 1'b0;
        bus.rptr_gray = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_full", int'(bus.full), 0);
        check("rst_wr_count", int'(bus.wr_count), 0);
        check("rst_wptr_gray", int'(bus.wptr_gray), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        rst_n = 1'b1;

        // Reset asserted between edges during a burst must clear state immediately.
        repeat (3) cycle(1'b1, 1'b0, 0);
        bus.wr_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_waddr", int'(bus.waddr), 0);
        check("async_rst_wptr_gray", int'(bus.wptr_gray), 0);
        check("async_rst_wr_count", int'(bus.wr_count), 0);
        check("async_rst_almost_full", int'(bus.almost_full), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Fill, overflow, clear priority.
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].wr, vecs[i].clr, 0);
            check($sformatf("vec%0d_we", i), pre_we, int'(vecs[i].we));
            check($sformatf("vec%0d_waddr", i), pre_waddr, vecs[i].waddr);
            check($sformatf("vec%0d_full", i), int'(bus.full), int'(vecs[i].full));
            check($sformatf("vec%0d_af", i), int'(bus.almost_full), int'(vecs[i].af));
            check($sformatf("vec%0d_cnt", i), int'(bus.wr_count), vecs[i].cnt);
            check($sformatf("vec%0d_gray", i), int'(bus.wptr_gray), vecs[i].gray);
            check($sformatf("vec%0d_ovf", i), int'(bus.overflow), int'(vecs[i].ovf));
        end

        // Read pointer advance reaches full/wr_count on the third edge.
        cycle(1'b0, 1'b0, 1);
        check("release_e1_full", int'(bus.full), 1);
        cycle(1'b0, 1'b0, 1);
        check("release_e2_full", int'(bus.full), 1);
        cycle(1'b0, 1'b0, 1);
        check("release_e3_full", int'(bus.full), 0);
        check("release_e3_cnt", int'(bus.wr_count), 7);

        // Wrap with the reader trailing four behind.
        repeat (3) cycle(1'b0, 1'b0, 4);
        wrap_seen = 0;
        for (int i = 0; i < 20; i++) begin
            prev_gray = int'(bus.wptr_gray);
            cycle(1'b1, 1'b0, m_wtot - 4);
            check("wrap_full", int'(bus.full), 0);
            check("wrap_gray_step", $countones(4'(prev_gray) ^ bus.wptr_gray), 1);
            if (pre_waddr == 7 && int'(bus.waddr) == 0) wrap_seen = 1;
        end
        check("wrap_seen", wrap_seen, 1);

        // Full detected across the binary wrap: wbin=12, reader at 4.
        check("wrap12_gray", int'(bus.wptr_gray), 10);
        repeat (3) cycle(1'b0, 1'b0, 4);
        check("wrap12_full", int'(bus.full), 1);
        check("wrap12_cnt", int'(bus.wr_count), 8);

        // Random traffic with a reader that never passes the writer.
        rb_i = m_wtot - 8;
        for (int i = 0; i < 300; i++) begin
            wr  = ($urandom % 4) != 0;
            clr = ($urandom % 8) == 0;
            if (($urandom % 2) == 1 && rb_i < m_wtot) rb_i++;
            cycle(wr, clr, rb_i);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
